// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: abcdefg patterns (seg[6]=a .. seg[0]=g),
// blank nibble code and the scan-decoder FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b0011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus side (seg/dig_en/clr_err) and decoded-status side of the scan decoder.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  localparam int IW = $clog2(NUM_DIGITS);

  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    clr_err;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    upd;
  logic [IW-1:0]           upd_idx;
  logic                    err_pulse;
  logic                    err_sticky;
  state_t                  dbg_state;

  // No backpressure: upd and err_pulse are single-cycle events that a consumer
  // must sample every cycle; upd_idx and bcd_out are valid in the cycle upd is high.
  modport master (
    output seg, dig_en, clr_err,
    input  bcd_out, digit_valid, blank, upd, upd_idx, err_pulse, err_sticky, dbg_state
  );

  modport slave (
    input  seg, dig_en, clr_err,
    output bcd_out, digit_valid, blank, upd, upd_idx, err_pulse, err_sticky, dbg_state
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational abcdefg pattern -> BCD nibble, blank flag and legality flag.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_is_blank,
  output logic       o_is_legal
);

  always_comb begin
    o_bcd      = 4'h0;
    o_is_blank = 1'b0;
    o_is_legal = 1'b1;
    case (i_seg)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: begin
        o_bcd      = BCD_BLANK;
        o_is_blank = 1'b1;
      end
      default:   o_is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment bus, waits for the strobe to settle, samples
// each digit and commits it once the same code is seen on consecutive scans.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_SCANS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int ND = NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [4:0] STABLE_N    = 5'(STABLE_SCANS);
  localparam state_t     ENTER_STATE = (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;

  logic [6:0]    r_seg_q;
  logic [ND-1:0] r_en_q, r_en_prev, r_cur_en;
  logic [IW-1:0] r_cur_idx;
  state_t        r_state;
  logic [7:0]    r_cnt;

  logic [3:0]    r_cand_bcd [ND];
  logic [3:0]    r_match    [ND];
  logic [ND-1:0] r_cand_blank, r_cand_vld;

  logic [4*ND-1:0] r_bcd_out;
  logic [ND-1:0]   r_digit_valid, r_blank;
  logic            r_upd, r_err_pulse, r_err_sticky;
  logic [IW-1:0]   r_upd_idx;

  logic [3:0]    w_bcd, w_next_match, w_cur_nib;
  logic          w_is_blank, w_is_legal;
  logic          w_zero, w_onehot, w_multi, w_moved;
  logic          w_same_cand, w_commit, w_changes;
  logic [IW-1:0] w_idx;

  seg7_pattern_decode u_decode (
    .i_seg      (r_seg_q),
    .o_bcd      (w_bcd),
    .o_is_blank (w_is_blank),
    .o_is_legal (w_is_legal)
  );

  assign w_zero   = (r_en_q == '0);
  assign w_onehot = $onehot(r_en_q);
  assign w_multi  = !w_zero && !w_onehot;
  // Any non-idle state abandons its digit as soon as the strobe leaves it.
  assign w_moved  = (r_state != ST_IDLE) && (r_en_q != r_cur_en);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < ND; i++) begin
      if (r_en_q[i]) w_idx = IW'(i);
    end
  end

  assign w_same_cand  = r_cand_vld[r_cur_idx] && (r_cand_bcd[r_cur_idx] == w_bcd) &&
                        (r_cand_blank[r_cur_idx] == w_is_blank);
  assign w_next_match = !w_same_cand ? 4'd0 :
                        (r_match[r_cur_idx] == 4'hF) ? 4'hF : r_match[r_cur_idx] + 4'd1;
  assign w_commit     = ({1'b0, w_next_match} + 5'd1) >= STABLE_N;
  assign w_cur_nib    = r_bcd_out[{r_cur_idx, 2'b00} +: 4];
  assign w_changes    = !r_digit_valid[r_cur_idx] || (w_cur_nib != w_bcd) ||
                        (r_blank[r_cur_idx] != w_is_blank);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_q       <= '0;
      r_en_q        <= '0;
      r_en_prev     <= '0;
      r_cur_en      <= '0;
      r_cur_idx     <= '0;
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cand_blank  <= '0;
      r_cand_vld    <= '0;
      for (int i = 0; i < ND; i++) begin
        r_cand_bcd[i] <= '0;
        r_match[i]    <= '0;
      end
      r_bcd_out     <= '0;
      r_digit_valid <= '0;
      r_blank       <= '0;
      r_upd         <= 1'b0;
      r_upd_idx     <= '0;
      r_err_pulse   <= 1'b0;
      r_err_sticky  <= 1'b0;
    end else begin
      r_seg_q     <= bus.seg;
      r_en_q      <= bus.dig_en;
      r_en_prev   <= r_en_q;
      r_upd       <= 1'b0;
      r_err_pulse <= 1'b0;
      if (bus.clr_err) r_err_sticky <= 1'b0;

      if (r_state == ST_IDLE || w_moved) begin
        if (w_onehot) begin
          r_cur_en  <= r_en_q;
          r_cur_idx <= w_idx;
          r_cnt     <= '0;
          r_state   <= ENTER_STATE;
        end else begin
          r_state <= ST_IDLE;
          // A multi-hot value parked in IDLE is reported only once.
          if (w_multi && (w_moved || (r_en_q != r_en_prev))) begin
            r_err_pulse  <= 1'b1;
            r_err_sticky <= 1'b1;
          end
        end
      end else begin
        case (r_state)
          ST_SETTLE: begin
            if ((r_cnt + 8'd1) >= SETTLE_LAST) r_state <= ST_SAMPLE;
            else r_cnt <= r_cnt + 8'd1;
          end
          ST_SAMPLE: begin
            r_state <= ST_HOLD;
            if (!w_is_legal) begin
              r_err_pulse             <= 1'b1;
              r_err_sticky            <= 1'b1;
              r_cand_vld[r_cur_idx]   <= 1'b0;
              r_match[r_cur_idx]      <= '0;
            end else begin
              r_cand_vld[r_cur_idx]   <= 1'b1;
              r_cand_bcd[r_cur_idx]   <= w_bcd;
              r_cand_blank[r_cur_idx] <= w_is_blank;
              r_match[r_cur_idx]      <= w_next_match;
              if (w_commit) begin
                r_bcd_out[{r_cur_idx, 2'b00} +: 4] <= w_bcd;
                r_blank[r_cur_idx]       <= w_is_blank;
                r_digit_valid[r_cur_idx] <= 1'b1;
                if (w_changes) begin
                  r_upd     <= 1'b1;
                  r_upd_idx <= r_cur_idx;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.bcd_out     = r_bcd_out;
  assign bus.digit_valid = r_digit_valid;
  assign bus.blank       = r_blank;
  assign bus.upd         = r_upd;
  assign bus.upd_idx     = r_upd_idx;
  assign bus.err_pulse   = r_err_pulse;
  assign bus.err_sticky  = r_err_sticky;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: expected upd events and error pulses are
// queued by the stimulus and retired by an independent monitor.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  localparam int W = 7; // {upd_idx[1:0], nibble[3:0], blank}

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .SETTLE_CYCLES (4),
    .STABLE_SCANS  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int err_exp  = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.upd) begin
        logic [W-1:0] got, exp;
        got = {bus.upd_idx, bus.bcd_out[bus.upd_idx*4 +: 4], bus.blank[bus.upd_idx]};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL upd_unexpected got={idx,nib,blank}=%b required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL upd_event got={idx,nib,blank}=%b required %b", got, exp);
          end
        end
      end
      if (bus.err_pulse) begin
        checks++;
        if (err_exp == 0) begin
          failures++;
          $display("FAIL err_unexpected got err_pulse=1 required 0");
        end else begin
          err_exp--;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0 || err_exp != 0) begin
      failures++;
      $display("FAIL %s pending_upd=%0d pending_err=%0d required 0 and 0",
               name, exp_q.size(), err_exp);
      exp_q.delete();
      err_exp = 0;
    end
  endtask

  task automatic expect_upd(input int d, input logic [3:0] nib, input logic blk);
    exp_q.push_back({2'(d), nib, blk});
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] s, input int n);
    bus.dig_en = en;
    bus.seg    = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int d, input logic [6:0] s);
    drive(4'(1 << d), s, 8);
    drive(4'b0000, s, 2);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_bcd"},   32'(bus.bcd_out), 32'h0);
    chk({name, "_valid"}, 32'(bus.digit_valid), 32'h0);
    chk({name, "_blank"}, 32'(bus.blank), 32'h0);
    chk({name, "_upd"},   32'(bus.upd), 32'h0);
    chk({name, "_stky"},  32'(bus.err_sticky), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.seg     = '0;
    bus.dig_en  = '0;
    bus.clr_err = 1'b0;

    // Reset with garbage on the bus
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.dig_en = 4'($urandom_range(0, 15));
      bus.seg    = 7'($urandom_range(0, 127));
    end
    @(negedge clk);
    chk_all_zero("reset");
    bus.dig_en = '0;
    bus.seg    = '0;
    rst        = 1'b0;
    repeat (5) @(negedge clk);
    chk_all_zero("idle");

    // Single digit: two scans to commit, third is silent
    scan(0, SEG_2);
    chk("single_first_valid", 32'(bus.digit_valid), 32'h0);
    drain("single_first");
    expect_upd(0, 4'd2, 1'b0);
    scan(0, SEG_2);
    drain("single_second");
    chk("single_nib", 32'(bus.bcd_out[3:0]), 32'h2);
    chk("single_valid", 32'(bus.digit_valid), 32'h1);
    scan(0, SEG_2);
    drain("single_third");

    // Full scan 1,9,8,7 on digits 3..0
    scan(3, SEG_1); scan(2, SEG_9); scan(1, SEG_8); scan(0, SEG_7);
    drain("full_first_pass");
    expect_upd(3, 4'd1, 1'b0); expect_upd(2, 4'd9, 1'b0);
    expect_upd(1, 4'd8, 1'b0); expect_upd(0, 4'd7, 1'b0);
    scan(3, SEG_1); scan(2, SEG_9); scan(1, SEG_8); scan(0, SEG_7);
    drain("full_second_pass");
    chk("full_bcd", 32'(bus.bcd_out), 32'h1987);
    chk("full_valid", 32'(bus.digit_valid), 32'hF);
    chk("full_blank", 32'(bus.blank), 32'h0);

    // Illegal pattern, multi-hot strobe, clear
    err_exp = 1;
    drive(4'b0100, 7'b1000000, 8);
    drive(4'b0000, 7'b1000000, 2);
    drain("err_illegal");
    chk("err_sticky_set", 32'(bus.err_sticky), 32'h1);
    chk("err_bcd_kept", 32'(bus.bcd_out), 32'h1987);
    err_exp = 1;
    drive(4'b0011, SEG_8, 8);
    drive(4'b0000, SEG_8, 2);
    drain("err_multihot");
    chk("multihot_bcd_kept", 32'(bus.bcd_out), 32'h1987);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("err_sticky_clr", 32'(bus.err_sticky), 32'h0);

    // Short strobe on digit 0 must not sample
    drive(4'b0001, SEG_5, 3);
    drive(4'b0010, SEG_8, 8);
    drive(4'b0000, SEG_8, 2);
    scan(0, SEG_5);
    drain("short_no_upd");
    chk("short_nib_kept", 32'(bus.bcd_out[3:0]), 32'h7);
    expect_upd(0, 4'd5, 1'b0);
    scan(0, SEG_5);
    drain("short_then_two");

    // Strobe length boundary: 4 cycles never samples, 5 cycles does
    drive(4'b1000, SEG_4, 4); drive(4'b0000, SEG_4, 2);
    drive(4'b1000, SEG_4, 4); drive(4'b0000, SEG_4, 2);
    drive(4'b1000, SEG_4, 5); drive(4'b0000, SEG_4, 2);
    drain("len4_no_sample");
    chk("len4_nib_kept", 32'(bus.bcd_out[15:12]), 32'h1);
    expect_upd(3, 4'd4, 1'b0);
    drive(4'b1000, SEG_4, 5); drive(4'b0000, SEG_4, 2);
    drain("len5_commit");

    // Reset during SETTLE after one qualifying sample of digit 1
    scan(1, SEG_3);
    drain("pre_reset_sample");
    drive(4'b0010, SEG_3, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("midreset");
    bus.dig_en = '0;
    rst        = 1'b0;
    repeat (2) @(negedge clk);
    scan(1, SEG_3);
    drain("post_reset_first");
    chk("post_reset_valid", 32'(bus.digit_valid), 32'h0);
    expect_upd(1, 4'd3, 1'b0);
    scan(1, SEG_3);
    drain("post_reset_second");
    chk("post_reset_bcd", 32'(bus.bcd_out), 32'h0030);

    // Blank then override on digit 2
    scan(2, SEG_BLANK);
    expect_upd(2, BCD_BLANK, 1'b1);
    scan(2, SEG_BLANK);
    drain("blank_commit");
    chk("blank_nib", 32'(bus.bcd_out[11:8]), 32'hF);
    chk("blank_flags", 32'(bus.blank), 32'h4);
    chk("blank_valid", 32'(bus.digit_valid), 32'h6);
    scan(2, SEG_6);
    expect_upd(2, 4'd6, 1'b0);
    scan(2, SEG_6);
    drain("override_commit");
    chk("override_blank", 32'(bus.blank), 32'h0);
    chk("override_bcd", 32'(bus.bcd_out), 32'h0630);

    repeat (3) @(negedge clk);
    drain("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
